// File: rtl/ct_unload_pkg.sv
// Shared types and helpers for the ciphertext unload stage.
// Default code parameters for ROLLO-I: N=83, M=67, DIGIT=4.
package ct_unload_pkg;

    localparam int CT_N     = 83;
    localparam int CT_M     = 67;
    localparam int CT_DIGIT = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LD,
        ST_SH,
        ST_FIN
    } ct_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Counter width that stays legal when only one value is ever needed.
    function automatic int idx_width(input int count);
        return (count > 1) ? clog2(count) : 1;
    endfunction

endpackage

// File: rtl/ct_unload_if.sv
// Memory read port plus output beat stream of the ciphertext unload stage.
interface ct_unload_if #(
    parameter int W     = 268,
    parameter int AW    = 5,
    parameter int OUT_W = 32
);
    logic [AW-1:0]    mem_addr;
    logic             mem_rw;
    logic [W-1:0]     mem_din;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output mem_addr, mem_rw, out_data, out_valid, out_last,
        input  mem_din, out_ready
    );

    modport slave (
        input  mem_addr, mem_rw, out_data, out_valid, out_last,
        output mem_din, out_ready
    );
endinterface

// File: rtl/ct_beat_shifter.sv
// Word buffer and beat index: slices a W-bit word into zero-padded OUT_W beats.
module ct_beat_shifter #(
    parameter int W     = 268,
    parameter int OUT_W = 32,
    parameter int BEATS = 9,
    parameter int BW    = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             load,
    input  logic [W-1:0]     din,
    input  logic             clear,
    input  logic             advance,
    output logic [OUT_W-1:0] beat,
    output logic             beat_last
);
    localparam int PAD_W = BEATS * OUT_W;

    logic [W-1:0]     word_reg;
    logic [BW-1:0]    bidx_reg;
    logic [PAD_W-1:0] padded;
    logic [OUT_W-1:0] beats [BEATS];

    // Bits above W read as zero so the top beat is padded.
    assign padded = PAD_W'(word_reg);

    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
        assign beats[gi] = padded[gi*OUT_W +: OUT_W];
    end

    assign beat      = beats[bidx_reg];
    assign beat_last = (bidx_reg == BW'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            word_reg <= '0;
            bidx_reg <= '0;
        end else begin
            if (load) word_reg <= din;
            if (clear) bidx_reg <= '0;
            else if (advance) bidx_reg <= bidx_reg + 1'b1;
        end
    end
endmodule

// File: rtl/ct_unload.sv
// Reads the ct memory word by word after encryption and streams each word as
// OUT_W-bit beats with a last marker; the address bus is zero outside RD.
module ct_unload
    import ct_unload_pkg::*;
#(
    parameter int N     = CT_N,
    parameter int M     = CT_M,
    parameter int DIGIT = CT_DIGIT,
    parameter int OUT_W = 32
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        start,
    ct_unload_if.master bus,
    output logic        busy,
    output logic        done
);
    localparam int W     = M * DIGIT;
    localparam int DEPTH = N / DIGIT + (((N % DIGIT) != 0) ? 1 : 0);
    localparam int BEATS = (W + OUT_W - 1) / OUT_W;
    localparam int AW    = idx_width(DEPTH);
    localparam int BW    = idx_width(BEATS);

    ct_state_t        state_reg, state_next;
    logic [AW-1:0]    widx_reg, widx_next;
    logic [AW-1:0]    addr_reg, addr_next;
    logic             buf_load, bidx_clear, bidx_adv;
    logic             beat_last, handshake, word_last;
    logic [OUT_W-1:0] beat;

    ct_beat_shifter #(
        .W(W), .OUT_W(OUT_W), .BEATS(BEATS), .BW(BW)
    ) u_shifter (
        .clk       (clk),
        .rst_b     (rst_b),
        .load      (buf_load),
        .din       (bus.mem_din),
        .clear     (bidx_clear),
        .advance   (bidx_adv),
        .beat      (beat),
        .beat_last (beat_last)
    );

    assign handshake = (state_reg == ST_SH) && bus.out_ready;
    assign word_last = (widx_reg == AW'(DEPTH - 1));

    always_comb begin
        state_next = state_reg;
        widx_next  = widx_reg;
        buf_load   = 1'b0;
        bidx_clear = 1'b0;
        bidx_adv   = 1'b0;
        case (state_reg)
            ST_IDLE: if (start) begin
                widx_next  = '0;
                bidx_clear = 1'b1;
                state_next = ST_RD;
            end
            ST_RD: state_next = ST_LD;
            ST_LD: begin
                buf_load   = 1'b1;
                state_next = ST_SH;
            end
            ST_SH: if (handshake) begin
                if (!beat_last) begin
                    bidx_adv = 1'b1;
                end else if (!word_last) begin
                    bidx_clear = 1'b1;
                    widx_next  = widx_reg + 1'b1;
                    state_next = ST_RD;
                end else begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        // Address is registered so it is clean to OR with other bus masters.
        addr_next = (state_next == ST_RD) ? widx_next : '0;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= ST_IDLE;
            widx_reg  <= '0;
            addr_reg  <= '0;
        end else begin
            state_reg <= state_next;
            widx_reg  <= widx_next;
            addr_reg  <= addr_next;
        end
    end

    assign bus.mem_addr  = addr_reg;
    assign bus.mem_rw    = 1'b0;
    assign bus.out_valid = (state_reg == ST_SH);
    assign bus.out_data  = bus.out_valid ? beat : '0;
    assign bus.out_last  = bus.out_valid && word_last && beat_last;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = (state_reg == ST_FIN);
endmodule

// File: tb/tb_ct_unload.sv
// Directed bench for ct_unload with a synchronous-read ct memory model.
module tb_ct_unload;
    import ct_unload_pkg::*;

    localparam int W     = CT_M * CT_DIGIT;
    localparam int DEPTH = 21;
    localparam int BEATS = 9;
    localparam int AW    = idx_width(DEPTH);
    localparam int TOTAL = DEPTH * BEATS;

    logic clk = 1'b0;
    logic rst_b;
    logic start;
    logic busy;
    logic done;

    ct_unload_if #(.W(W), .AW(AW), .OUT_W(32)) bus ();

    ct_unload dut (
        .clk   (clk),
        .rst_b (rst_b),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [DEPTH];

    always @(posedge clk)
        bus.mem_din <= (int'(bus.mem_addr) < DEPTH) ? mem[bus.mem_addr] : '0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] got_q[$];
    logic [31:0] ref_q[$];
    logic        last_q[$];
    int          addr_q[$];
    int          done_cyc, addr_bad, rw_bad, stall_bad;
    logic        aborted;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic preload();
        for (int k = 0; k < DEPTH; k++) begin
            mem[k] = '0;
            for (int d = 0; d < CT_DIGIT; d++)
                mem[k][d*CT_M +: CT_M] = CT_M'(k[7:0]);
        end
    endtask

    function automatic logic [31:0] exp_beat(input int w, input int b);
        logic [BEATS*32-1:0] p;
        p = '0;
        p[W-1:0] = mem[w];
        return p[b*32 +: 32];
    endfunction

    function automatic int model_errs();
        int e = 0;
        for (int i = 0; i < got_q.size() && i < TOTAL; i++)
            if (got_q[i] !== exp_beat(i / BEATS, i % BEATS)) e++;
        return e;
    endfunction

    function automatic int ref_errs();
        int e = 0;
        for (int i = 0; i < got_q.size() && i < ref_q.size(); i++)
            if (got_q[i] !== ref_q[i]) e++;
        return e;
    endfunction

    function automatic int last_count();
        int c = 0;
        foreach (last_q[i]) if (last_q[i]) c++;
        return c;
    endfunction

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: ready high; 1: ready toggles; 2: extra start at widx 5; 3: reset at widx 10
    task automatic run(input int mode);
        int   cyc;
        logic rd_next, pv, pr, pulsed;
        logic [31:0] pd;
        got_q.delete(); last_q.delete(); addr_q.delete();
        done_cyc = -1; addr_bad = 0; rw_bad = 0; stall_bad = 0;
        aborted = 1'b0; pv = 1'b0; pr = 1'b0; pd = '0; pulsed = 1'b0;
        bus.out_ready = 1'b1;
        do_start();
        rd_next = 1'b1;
        cyc = 0;
        while (cyc < 2000 && done_cyc < 0) begin
            bus.out_ready = (mode == 1) ? ((cyc % 2) == 0) : 1'b1;
            if (rd_next) addr_q.push_back(int'(bus.mem_addr));
            else if (bus.mem_addr != '0) addr_bad++;
            rd_next = 1'b0;
            if (bus.mem_rw) rw_bad++;
            if (pv && !pr && (!bus.out_valid || bus.out_data != pd)) stall_bad++;
            if (bus.out_valid && bus.out_ready) begin
                got_q.push_back(bus.out_data);
                last_q.push_back(bus.out_last);
                if (got_q.size() % BEATS == 0 && got_q.size() < TOTAL) rd_next = 1'b1;
            end
            if (done) done_cyc = cyc;
            pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data;
            if (mode == 3 && got_q.size() == 10*BEATS + 3) begin
                rst_b = 1'b0;
                #1;
                check("rst_mid_busy",  64'(busy), 64'(0));
                check("rst_mid_valid", 64'(bus.out_valid), 64'(0));
                check("rst_mid_last",  64'(bus.out_last), 64'(0));
                check("rst_mid_done",  64'(done), 64'(0));
                check("rst_mid_addr",  64'(bus.mem_addr), 64'(0));
                check("rst_mid_data",  64'(bus.out_data), 64'(0));
                aborted = 1'b1;
                break;
            end
            if (mode == 2 && !pulsed && got_q.size() == 5*BEATS + 2) begin
                start = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (mode == 3) check("rst_reached", 64'(aborted), 64'(1));
        else           check("done_seen", 64'(done_cyc >= 0), 64'(1));
    endtask

    task automatic check_full(input string tag);
        check({tag, "_beats"},   64'(got_q.size()), 64'(TOTAL));
        check({tag, "_model"},   64'(model_errs()), 64'(0));
        check({tag, "_lastcnt"}, 64'(last_count()), 64'(1));
        if (last_q.size() > 0) check({tag, "_lastpos"}, 64'(last_q[last_q.size()-1]), 64'(1));
        check({tag, "_donecyc"}, 64'(done_cyc), 64'(231));
    endtask

    initial begin
        rst_b = 1'b0; start = 1'b0; bus.out_ready = 1'b0;
        preload();
        repeat (3) @(negedge clk);
        check("rst_busy",  64'(busy), 64'(0));
        check("rst_valid", 64'(bus.out_valid), 64'(0));
        check("rst_last",  64'(bus.out_last), 64'(0));
        check("rst_done",  64'(done), 64'(0));
        check("rst_addr",  64'(bus.mem_addr), 64'(0));
        check("rst_data",  64'(bus.out_data), 64'(0));
        check("rst_rw",    64'(bus.mem_rw), 64'(0));
        rst_b = 1'b1;
        @(negedge clk);

        run(0);
        check_full("run0");
        if (got_q.size() == TOTAL) begin
            check("w0b0", 64'(got_q[0]),  64'h0);
            check("w1b0", 64'(got_q[9]),  64'h1);
            check("w1b2", 64'(got_q[11]), 64'h8);
            check("w3b6", 64'(got_q[33]), 64'h600);
        end
        check("addr_cnt", 64'(addr_q.size()), 64'(DEPTH));
        begin
            int e = 0;
            foreach (addr_q[i]) if (addr_q[i] != i) e++;
            check("addr_seq", 64'(e), 64'(0));
        end
        check("addr_idle0", 64'(addr_bad), 64'(0));
        check("rw_zero",    64'(rw_bad), 64'(0));
        ref_q = got_q;

        run(1);
        check("tog_beats",  64'(got_q.size()), 64'(TOTAL));
        check("tog_same",   64'(ref_errs()), 64'(0));
        check("tog_stall",  64'(stall_bad), 64'(0));
        check("tog_lastcnt", 64'(last_count()), 64'(1));

        mem[20] = '1;
        run(0);
        check_full("ones");
        if (got_q.size() == TOTAL) begin
            check("w20b0", 64'(got_q[180]), 64'hFFFF_FFFF);
            check("w20b8", 64'(got_q[188]), 64'h0000_0FFF);
        end
        preload();

        run(2);
        check_full("midstart");
        check("midstart_same", 64'(ref_errs()), 64'(0));

        run(3);
        @(negedge clk);
        check("rst_hold_busy", 64'(busy), 64'(0));
        rst_b = 1'b1;
        @(negedge clk);

        run(0);
        check_full("restart");
        check("restart_same", 64'(ref_errs()), 64'(0));

        run(0);
        check_full("b2b");
        check("b2b_same", 64'(ref_errs()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ct_unload.md
# ct_unload

Ciphertext unload stage that runs after ROLLO-I encryption. Once the encrypt core signals `ready`, this block reads the ciphertext memory word by word. Each word is `M*DIGIT` bits. The block streams the words out as 32-bit beats over a valid/ready handshake, with a last-beat marker. It is the consumer of the `ct` single-port memory and shares that memory's address bus by OR-combining, so it must drive zero on the bus whenever it is not reading.

## Interface
- `N`, default `N` from define.v: code length, i.e. coefficients per ciphertext.
- `M`, default `M` from define.v: field degree, i.e. bits per coefficient.
- `DIGIT`, default `DIGIT` from define.v: coefficients per memory word.
- `OUT_W`, default 32: output beat width.
- Derived values (localparam, not overridable):
  - `W = M*DIGIT`
  - `DEPTH = N/DIGIT + (N%DIGIT != 0)`
  - `BEATS = ceil(W/OUT_W)`
  - `AW = CLOG2(DEPTH)`

Ports (clock and reset first):
- `clk` input 1: single clock, rising edge.
- `rst_b` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins an unload; sampled only in IDLE.
- `mem_addr` output `AW`: ct memory read address; 0 whenever not in RD.
- `mem_rw` output 1: tied 0; this block never writes.
- `mem_din` input `W`: ct memory read data, valid one cycle after the address.
- `out_data` output `OUT_W`: current beat.
- `out_valid` output 1: beat available.
- `out_ready` input 1: downstream accepts the beat.
- `out_last` output 1: high with the final beat of the final word.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse after the final handshake.

## Operation
- States: IDLE, RD, LD, SH, FIN.
- IDLE:
  - All outputs are 0.
  - `start=1` clears the word counter `widx` and beat counter `bidx`, then moves to RD.
  - `start` in any other state is ignored.
- RD: drive `mem_addr = widx` for one cycle, then go to LD.
- LD: capture `mem_din` into the W-bit word buffer, then go to SH.
- SH:
  - `out_valid=1`.
  - `out_data` = buffer bits `[bidx*32 +: 32]`. Bits at or above W read as 0, so the top beat is zero-padded: with W=268, beat 8 carries bits 256..267 in `[11:0]` and `[31:12]=0`.
  - On a handshake (`out_valid & out_ready`):
    - If `bidx < BEATS-1`: increment `bidx`.
    - Else if `widx < DEPTH-1`: `bidx←0`, `widx←widx+1`, go to RD.
    - Else go to FIN.
  - Without `out_ready`: `out_data`, `bidx` and `widx` hold stable. No beat is dropped or repeated.
- `out_last = out_valid & (widx==DEPTH-1) & (bidx==BEATS-1)`.
- FIN: `done=1` for one cycle, then IDLE.
- Partial last word (`N%DIGIT≠0`): the whole word is still emitted. The unused coefficient slots carry whatever memory holds; the block does not mask them.
- A new `start` in IDLE right after FIN restarts from word 0.
- Reset:
  - Asserting `rst_b` in any state forces IDLE.
  - Buffer and counters clear to 0.
  - `out_valid`, `out_last`, `busy`, `done` and `mem_addr` go to 0 immediately (asynchronously).

## Timing
- Reset values: every output 0.
- `start` sampled at edge T0: RD during cycle T0..T1, LD during T1..T2, first `out_valid` in cycle T2..T3.
- Per-word overhead is 2 cycles (RD, LD) with no prefetch.
- With `out_ready` held high, the last handshake occurs `DEPTH*(BEATS+2)` cycles after T0. `done` is asserted in the following cycle.
- Defaults M=67, DIGIT=4, N=83 give W=268, BEATS=9, DEPTH=21. That is 231 cycles, with `done` in cycle 231.
- `out_valid` never drops while in SH until the handshake completes (AXI-stream style).
- `mem_addr` is registered and non-zero only during RD, so it is safe to OR with other address sources.

## Structure
- `N`, `M`, `DIGIT` come from define.v; `CLOG2` comes from clog2.v. No new shared constants.
- Derived localparams stay local to the block.
- One natural sub-module: `ct_beat_shifter`.
  - Holds the W-bit buffer and the beat index.
  - Provides load, advance and zero-pad select.
  - The FSM and word counter stay in `ct_unload`.

## Test plan
- Reset, then memory preloaded with word k = {DIGIT copies of k[7:0] in each M-bit coefficient}; `start` with `out_ready=1` → 189 beats, beat 0 of word 0 = 0x00000000, `out_last` only on beat 189, `done` in cycle 231.
- Word 20 buffer = all ones, W=268 → beat 8 of that word = 0x00000FFF.
- `out_ready` toggling 1-0-1 each cycle → identical beat sequence to the previous case, no duplicates, `out_data` stable while stalled.
- Check `mem_addr` over a full run → non-zero only in RD, values 0,1,…,20 each presented exactly once, `mem_rw` always 0.
- `start` pulsed again mid-stream (widx=5) → ignored, sequence unchanged; `rst_b` low at widx=10 → all outputs 0 at once; re-`start` restarts from word 0.
- Back-to-back: `start` in the cycle after `done` → second full run with an identical beat stream.
